uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 25 ++
 rtl/uart_tx.sv | 149 ++++++++++++++
 tb/tb_uart_tx.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmitter.
//   - parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD)
//   - FSM state encodings (IDLE, SYNC, START, DATA, PARITY, STOP)
//   - parity_bit(): turns the XOR of a payload into the transmitted parity bit
package uart_tx_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] S_SYNC   = 3'd1;
   localparam logic [STATE_W-1:0] S_START  = 3'd2;
   localparam logic [STATE_W-1:0] S_DATA   = 3'd3;
   localparam logic [STATE_W-1:0] S_PARITY = 3'd4;
   localparam logic [STATE_W-1:0] S_STOP   = 3'd5;

   // Even parity sends the payload XOR; odd parity sends its inverse.
   function automatic logic parity_bit(input int unsigned mode, input logic xor_all);
      return (mode == PAR_ODD) ? ~xor_all : xor_all;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter paced by an external bit-rate enable (cke).
// Frame: start(0), DATA_W payload bits LSB first, optional parity, STOP_BITS stop(1).
// Ports:
//   clk    - system clock, rising edge
//   rst_   - synchronous active-low reset
//   cke    - one-cycle bit-rate enable pulse
//   valid  - upstream offers data
//   data   - payload [DATA_W-1:0]
//   ready  - block idle and accepting (registered)
//   tx     - serial line, idle high (registered)
//   busy   - frame in progress, inverse of ready (registered)
//   done   - one-cycle pulse at end of frame (registered)
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              cke,
   input  logic              valid,
   input  logic [DATA_W-1:0] data,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   // Reject illegal configurations at elaboration.
   if (DATA_W < 5 || DATA_W > 9 || PARITY > PAR_ODD ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
      $fatal(1, "uart_tx: illegal parameter combination");
   end

   logic [STATE_W-1:0] state, state_n;
   logic [DATA_W-1:0]  shift, shift_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               stop_cnt, stop_cnt_n;
   logic               par, par_n;
   logic               tx_n;
   logic               done_n;

   // State and output registers; tx/done/ready/busy all come straight from flops.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state    <= S_IDLE;
         shift    <= '0;
         cnt      <= '0;
         stop_cnt <= 1'b0;
         par      <= 1'b0;
         tx       <= 1'b1;
         done     <= 1'b0;
         ready    <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         shift    <= shift_n;
         cnt      <= cnt_n;
         stop_cnt <= stop_cnt_n;
         par      <= par_n;
         tx       <= tx_n;
         done     <= done_n;
         ready    <= (state_n == S_IDLE);
         busy     <= (state_n != S_IDLE);
      end
   end

   // Next-state and next-output logic; every bit transition happens on a cke.
   always_comb begin
      state_n    = state;
      shift_n    = shift;
      cnt_n      = cnt;
      stop_cnt_n = stop_cnt;
      par_n      = par;
      tx_n       = tx;
      done_n     = 1'b0;

      case (state)
         S_IDLE: begin
            tx_n = 1'b1;
            // cke here is ignored so SYNC always waits for a later pulse.
            if (valid) begin
               shift_n = data;
               par_n   = parity_bit(PARITY, ^data);
               state_n = S_SYNC;
            end
         end
         S_SYNC: begin
            if (cke) begin
               tx_n    = 1'b0;
               state_n = S_START;
            end
         end
         S_START: begin
            if (cke) begin
               tx_n    = shift[0];
               cnt_n   = '0;
               state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (cke) begin
               if (cnt == LAST_BIT) begin
                  if (PARITY != PAR_NONE) begin
                     tx_n    = par;
                     state_n = S_PARITY;
                  end else begin
                     tx_n       = 1'b1;
                     stop_cnt_n = 1'b0;
                     state_n    = S_STOP;
                  end
               end else begin
                  // shift[1] becomes shift[0] after this shift, so it is the next bit.
                  shift_n = shift >> 1;
                  tx_n    = shift[1];
                  cnt_n   = cnt + CNT_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (cke) begin
               tx_n       = 1'b1;
               stop_cnt_n = 1'b0;
               state_n    = S_STOP;
            end
         end
         S_STOP: begin
            if (cke) begin
               if (stop_cnt == 1'(STOP_BITS - 1)) begin
                  done_n  = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  stop_cnt_n = stop_cnt + 1'b1;
               end
            end
         end
         default: begin
            tx_n    = 1'b1;
            state_n = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Three instances (no parity/1 stop, even parity/2 stop, odd parity/1 stop) are
// checked every cycle against a frame-level model: each accepted payload becomes
// a list of line bits, and the k-th cke after acceptance puts bit k-1 on tx.
module tb_uart_tx;

   localparam int unsigned NDUT = 3;

   logic       clk = 1'b0;
   logic       rst_;
   logic       cke;
   logic       valid_v [NDUT];
   logic [7:0] data_v  [NDUT];
   logic       ready_v [NDUT];
   logic       tx_v    [NDUT];
   logic       busy_v  [NDUT];
   logic       done_v  [NDUT];

   always #5 clk = ~clk;

   uart_tx #(.DATA_W(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst_(rst_), .cke(cke), .valid(valid_v[0]), .data(data_v[0]),
      .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   uart_tx #(.DATA_W(8), .PARITY(1), .STOP_BITS(2)) u1 (
      .clk(clk), .rst_(rst_), .cke(cke), .valid(valid_v[1]), .data(data_v[1]),
      .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   uart_tx #(.DATA_W(8), .PARITY(2), .STOP_BITS(1)) u2 (
      .clk(clk), .rst_(rst_), .cke(cke), .valid(valid_v[2]), .data(data_v[2]),
      .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int ck_per      = 4;   // 0 = random cke

   // Frame-level reference model state
   bit in_f   [NDUT];
   int k      [NDUT];
   int len    [NDUT];
   bit bits   [NDUT][16];
   bit e_tx   [NDUT];
   bit e_done [NDUT];
   int acc    [NDUT];
   int done_seen [NDUT];

   function automatic int par_of(int i);
      return (i == 0) ? 0 : (i == 1) ? 1 : 2;
   endfunction

   function automatic int stops_of(int i);
      return (i == 1) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input int i, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s u%0d cyc %0d: observed %b expected %b", tag, i, cyc, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic build_frame(input int i, input logic [7:0] d);
      len[i] = 0;
      bits[i][len[i]] = 1'b0; len[i]++;
      for (int b = 0; b < 8; b++) begin
         bits[i][len[i]] = d[b]; len[i]++;
      end
      if (par_of(i) != 0) begin
         bits[i][len[i]] = (^d) ^ (par_of(i) == 2); len[i]++;
      end
      for (int s = 0; s < stops_of(i); s++) begin
         bits[i][len[i]] = 1'b1; len[i]++;
      end
   endtask

   task automatic model_edge(input int i);
      e_done[i] = 1'b0;
      if (!rst_) begin
         in_f[i] = 1'b0;
         k[i]    = 0;
         e_tx[i] = 1'b1;
      end else if (!in_f[i]) begin
         e_tx[i] = 1'b1;
         if (valid_v[i]) begin
            in_f[i] = 1'b1;
            k[i]    = 0;
            build_frame(i, data_v[i]);
            acc[i]++;
         end
      end else if (cke) begin
         k[i]++;
         if (k[i] == len[i] + 1) begin
            in_f[i]   = 1'b0;
            e_done[i] = 1'b1;
            e_tx[i]   = 1'b1;
         end else begin
            e_tx[i] = bits[i][k[i]-1];
         end
      end
   endtask

   // One clock: choose cke, advance the model at the edge, check #1 later.
   task automatic step();
      if (ck_per == 0) cke = ($urandom_range(0, 2) == 0);
      else             cke = ((cyc % ck_per) == 0);
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NDUT; i++) model_edge(i);
      #1;
      for (int i = 0; i < NDUT; i++) begin
         chk("tx",    i, tx_v[i],    e_tx[i]);
         chk("done",  i, done_v[i],  e_done[i]);
         chk("ready", i, ready_v[i], !in_f[i]);
         chk("busy",  i, busy_v[i],  in_f[i]);
         if (done_v[i] === 1'b1) done_seen[i]++;
      end
   endtask

   task automatic send(input int i, input logic [7:0] d);
      valid_v[i] = 1'b1;
      data_v[i]  = d;
      step();
      valid_v[i] = 1'b0;
   endtask

   initial begin
      int d0;
      int lat;
      rst_ = 1'b0;
      cke  = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         valid_v[i] = 1'b0; data_v[i] = 8'h00;
         in_f[i] = 1'b0; k[i] = 0; acc[i] = 0; done_seen[i] = 0;
         e_tx[i] = 1'b1; e_done[i] = 1'b0;
      end

      // Reset state
      repeat (3) step();
      rst_ = 1'b1;
      repeat (2) step();

      // 0x55, no parity, cke every 4
      ck_per = 4;
      send(0, 8'h55);
      repeat (60) step();

      // Parity: 0x01 even and odd together, then 0x55 even
      send(1, 8'h01);
      valid_v[2] = 1'b1; data_v[2] = 8'h01;
      step();
      valid_v[2] = 1'b0;
      repeat (70) step();
      send(1, 8'h55);
      repeat (70) step();

      // Back-to-back with valid held high, two stop bits
      d0 = done_seen[1];
      lat = acc[1];
      valid_v[1] = 1'b1; data_v[1] = 8'hA3;
      for (int n = 0; n < 200 && acc[1] < lat + 1; n++) step();
      data_v[1] = 8'h3C;
      for (int n = 0; n < 200 && acc[1] < lat + 2; n++) step();
      valid_v[1] = 1'b0;
      repeat (70) step();
      chk_int("b2b_done_count", done_seen[1] - d0, 2);

      // Reset during data bit 3, then 0xFF
      d0 = done_seen[0];
      send(0, 8'hA5);
      for (int n = 0; n < 100 && k[0] < 5; n++) step();
      step();
      rst_ = 1'b0;
      step();
      rst_ = 1'b1;
      repeat (4) step();
      chk_int("abort_no_done", done_seen[0] - d0, 0);
      send(0, 8'hFF);
      repeat (60) step();

      // cke tied high: 0x80, done 11 clk after the accept edge
      ck_per = 1;
      send(0, 8'h80);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (done_v[0] === 1'b1) begin
            lat = n;
            break;
         end
      end
      chk_int("cke_high_latency", lat, 11);
      repeat (3) step();

      // valid pulsed while busy is ignored
      ck_per = 4;
      send(0, 8'h3A);
      repeat (10) step();
      send(0, 8'h11);
      repeat (60) step();

      // Random traffic on all instances with random cke
      ck_per = 0;
      repeat (800) begin
         for (int i = 0; i < NDUT; i++) begin
            valid_v[i] = ($urandom_range(0, 3) == 0);
            data_v[i]  = 8'($urandom);
         end
         step();
      end
      for (int i = 0; i < NDUT; i++) valid_v[i] = 1'b0;
      repeat (120) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
